seq_signed_divider: RTL
=======================

Name: seq_signed_divider

Overview:
- Sequential two's-complement divider; the inverse of the team's signed array multiplier.
- Computes quotient and remainder of a signed WIDTH-bit dividend by a signed WIDTH-bit divisor.
- Uses restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath; the bench can check it round-trip against the multiplier.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..16.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  signed dividend, two's complement
- b  input  WIDTH  signed divisor, two's complement
- q  output  WIDTH  signed quotient
- r  output  WIDTH  signed remainder
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; q/r valid from this cycle
- dz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: q=0, r=0, busy=0, done=0, dz=0 (and ovf=0); state=IDLE.
- Reset mid-operation aborts the operation with no done pulse.
- Semantics: truncation toward zero. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). |r| < |b|. a = q*b + r.
- Internal datapath:
  - |a| and |b| held as WIDTH-bit unsigned, so |-2^(W-1)| fits.
  - Partial remainder is WIDTH+1 bits.
  - Bit counter is ceil(log2(WIDTH+1)) bits.
- IDLE state: busy=0. On start=1 at edge k, latch magnitudes and signs, clear the partial remainder, and set busy=1.
  - b != 0: go to CALC, counter = WIDTH-1.
  - b == 0: go to FIX.
- CALC state, edges k+1..k+WIDTH:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract |b|; if non-negative, keep the difference and set quotient bit 1, else restore and set bit 0.
  - Counter decrements; after the counter-0 iteration go to FIX.
- FIX state, one edge:
  - Apply sign correction, register q/r, pulse done=1, busy=0, update dz; return to IDLE.
  - Normal latency: done high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles from start.
- Divide by zero: q = all ones (-1), r = a, dz=1. done is high the cycle after edge k+1.
- Outputs q, r, dz hold until the next completing operation.
- start while busy=1: ignored; a and b are not re-sampled.
- start in the same cycle done=1: accepted, because state is already IDLE.
- a, b may change freely after the start edge.
- Overflow case a=-2^(W-1), b=-1: q wraps to -2^(W-1), r=0, dz=0.

Optional Feature:
- Macro: SEQ_SIGNED_DIVIDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is registered in FIX: set when a==-2^(W-1) and b==-1, cleared on every other completed operation.
- Undefined: no ovf port; overflow case produces the wrapped result silently.
- q/r values are identical in both builds.

Decomposition:
- Shared package arith_pkg:
  - State encoding constants IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - Default WIDTH constant.
  - Helper function for counter width (clog2).
  - Reused by the multiplier bench.
- One natural sub-module, div_step: combinational single-iteration cell.
  - Inputs: shifted partial remainder (WIDTH+1), |b|.
  - Outputs: next remainder, quotient bit.
  - Built on ripple subtraction.
  - Instantiated once in the top; the top owns the FSM, counter, and sign correction.

Test Plan (WIDTH=4):
- Positive operands: a=7, b=2 -> q=4'd3, r=4'd1, dz=0; done exactly 6 cycles after start, one cycle wide.
- Mixed signs:
  - a=-7 (1001), b=2 -> q=1101 (-3), r=1111 (-1).
  - a=7, b=-2 (1110) -> q=1101, r=0001.
  - a=-7, b=-2 -> q=0011, r=1111.
- Divide by zero: a=5, b=0 -> q=1111, r=0101, dz=1; done 2 cycles after start. Next op a=6, b=3 clears dz, giving q=2, r=0.
- Overflow: a=1000, b=1111 -> q=1000, r=0000, dz=0; ovf=1 when SEQ_SIGNED_DIVIDER_OVF_EN is defined.
- Handshake:
  - start pulsed again at cycles 2–3 of a busy op is ignored; result still matches the first operands.
  - rst asserted at cycle 3 of an op -> all outputs 0 next cycle, no done pulse.
  - start in the same cycle as done is accepted.
- Exhaustive check: all 240 pairs with b!=0 against Verilog signed / and %, with the a=-8, b=-1 case expecting the wrapped result; back-to-back starts with no idle gap.

Source files
------------

// File: rtl/arith_pkg.sv
// ============================================================================
// Package : arith_pkg
// Brief   : Shared constants, FSM encoding and helpers for the arithmetic datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division iteration: ripple trial subtract and restore.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_shift_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0]   w_dsr_ext;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_borrow;

    assign w_dsr_ext   = {1'b0, dsr_i};
    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
        assign w_diff[i]     = rem_shift_i[i] ^ w_dsr_ext[i] ^ w_borrow[i];
        assign w_borrow[i+1] = (~rem_shift_i[i] & w_dsr_ext[i])
                             | (~(rem_shift_i[i] ^ w_dsr_ext[i]) & w_borrow[i]);
    end

    // A final borrow means the trial went negative: keep the old remainder.
    assign qbit_o = ~w_borrow[WIDTH+1];
    assign rem_o  = qbit_o ? w_diff : rem_shift_i;

endmodule

`default_nettype wire

// File: rtl/seq_signed_divider.sv
// ============================================================================
// Module  : seq_signed_divider
// Brief   : Sequential signed restoring divider, truncating toward zero.
//           Optional ovf output enabled by defining SEQ_SIGNED_DIVIDER_OVF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_signed_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dzp_q, dzp_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
    logic             ovfp_q, ovfp_d;
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_next;
    logic             w_qbit;

    // The dividend register doubles as the quotient shift register.
    assign w_rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_shift_i (w_rem_shift),
        .dsr_i       (dsr_q),
        .rem_o       (w_rem_next),
        .qbit_o      (w_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dzp_d   = dzp_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
        ovfp_d  = ovfp_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    negq_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    negr_d  = a[WIDTH-1];
                    dvd_d   = a[WIDTH-1] ? (~a + 1'b1) : a;
                    dsr_d   = b[WIDTH-1] ? (~b + 1'b1) : b;
                    rem_d   = '0;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    dzp_d   = (b == '0);
                    state_d = (b == '0) ? FIX : CALC;
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
                    ovfp_d  = (a == MIN_VAL) && (b == '1);
`endif
                end
            end
            CALC: begin
                rem_d = w_rem_next;
                dvd_d = {dvd_q[WIDTH-2:0], w_qbit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = dzp_q;
                state_d = IDLE;
                if (dzp_q) begin
                    // Divide by zero: dividend magnitude is still untouched in dvd_q.
                    q_d = '1;
                    r_d = negr_q ? (~dvd_q + 1'b1) : dvd_q;
                end else begin
                    q_d = negq_q ? (~dvd_q + 1'b1) : dvd_q;
                    r_d = negr_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                end
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
                ovf_d   = ovfp_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dzp_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
            ovfp_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dzp_q   <= dzp_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
            ovfp_q  <= ovfp_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
`ifdef SEQ_SIGNED_DIVIDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire
